// File: rtl/cnn_mac_pkg.sv
// Shared width defaults and arithmetic helpers for the pipelined conv/fc MAC unit.
// Helpers work on a 64-bit signed carrier so any legal ACC_W/OUT_W combination fits.
package cnn_mac_pkg;

    localparam int DEF_A_W          = 10;
    localparam int DEF_B_W          = 14;
    localparam int DEF_ACC_W        = 32;
    localparam int DEF_OUT_W        = 16;
    localparam int DEF_SHIFT        = 8;
    localparam int DEF_MUL_STAGES   = 2;
    localparam int MUL_STAGES_MIN   = 1;
    localparam int MUL_STAGES_MAX   = 3;
    localparam int CALC_W           = 64;

    function automatic bit mul_stages_ok(input int n);
        return (n >= MUL_STAGES_MIN) && (n <= MUL_STAGES_MAX);
    endfunction

    // Round-half-up arithmetic right shift; shift of zero passes the value through.
    function automatic logic signed [CALC_W-1:0] round_shift(input logic signed [CALC_W-1:0] v,
                                                             input int sh);
        logic signed [CALC_W-1:0] half;
        half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (v + half) >>> sh;
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_clip(input logic signed [CALC_W-1:0] v,
                                                          input int ow);
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        return v;
    endfunction

    function automatic logic sat_hit(input logic signed [CALC_W-1:0] v, input int ow);
        logic signed [CALC_W-1:0] max_v;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        return (v > max_v) || (v < (-max_v - 64'sd1));
    endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed A*B with STAGES clock-enabled registers; valid/first/last travel alongside the product.
// Data registers carry no reset so synthesis can fold them into the DSP pipeline registers.
module cnn_mac_mul_pipe #(
    parameter int A_W    = 10,
    parameter int B_W    = 14,
    parameter int ACC_W  = 32,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    beat_valid,
    input  logic                    beat_first,
    input  logic                    beat_last,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] prod,
    output logic                    prod_valid,
    output logic                    prod_first,
    output logic                    prod_last
);

    logic signed [A_W+B_W-1:0] mul;
    assign mul = a * b;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic signed [A_W+B_W-1:0] p_reg;
        logic                      v_reg;
        logic                      f_reg;
        logic                      l_reg;

        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (ce) begin
                    p_reg <= mul;
                    f_reg <= beat_first;
                    l_reg <= beat_last;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n)
                    v_reg <= 1'b0;
                else if (ce)
                    v_reg <= beat_valid;
            end
        end else begin : g_body
            always_ff @(posedge clk) begin
                if (ce) begin
                    p_reg <= g_stage[gi-1].p_reg;
                    f_reg <= g_stage[gi-1].f_reg;
                    l_reg <= g_stage[gi-1].l_reg;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n)
                    v_reg <= 1'b0;
                else if (ce)
                    v_reg <= g_stage[gi-1].v_reg;
            end
        end
    end

    assign prod       = ACC_W'(g_stage[STAGES-1].p_reg);
    assign prod_valid = g_stage[STAGES-1].v_reg;
    assign prod_first = g_stage[STAGES-1].f_reg;
    assign prod_last  = g_stage[STAGES-1].l_reg;

endmodule

// File: rtl/cnn_mac_pipe_dsp.sv
// Pipelined signed MAC: product pipe -> accumulator -> round/saturate output register.
// A single global stall (held result not taken) freezes every stage, so in_ready is combinational.
module cnn_mac_pipe_dsp import cnn_mac_pkg::*; #(
    parameter int A_W        = DEF_A_W,
    parameter int B_W        = DEF_B_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int MUL_STAGES = DEF_MUL_STAGES,
    parameter bit ACCUM_EN   = 1'b1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   din0,
    input  logic signed [B_W-1:0]   din1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_sat
);

    if (!mul_stages_ok(MUL_STAGES) || (ACC_W < A_W + B_W) || (ACC_W >= CALC_W)) begin : g_param_err
        $error("cnn_mac_pipe_dsp: illegal MUL_STAGES or ACC_W");
    end

    logic                    stall;
    logic                    ce;
    logic                    accept;
    logic                    beat_first;
    logic                    beat_last;
    logic signed [ACC_W-1:0] prod;
    logic                    prod_valid;
    logic                    prod_first;
    logic                    prod_last;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    res_valid_reg;
    logic signed [CALC_W-1:0] acc_wide;
    logic signed [CALC_W-1:0] rnd;

    assign stall    = out_valid & ~out_ready;
    assign ce       = ~stall;
    assign in_ready = ap_rst_n & ~stall;
    assign accept   = in_valid & in_ready;

    // Without accumulation every beat is a complete single-product result.
    assign beat_first = ACCUM_EN ? in_first : 1'b1;
    assign beat_last  = ACCUM_EN ? in_last  : 1'b1;

    cnn_mac_mul_pipe #(
        .A_W    (A_W),
        .B_W    (B_W),
        .ACC_W  (ACC_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .ce         (ce),
        .beat_valid (accept),
        .beat_first (beat_first),
        .beat_last  (beat_last),
        .a          (din0),
        .b          (din1),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_first (prod_first),
        .prod_last  (prod_last)
    );

    assign acc_wide = CALC_W'(acc_reg);
    assign rnd      = round_shift(acc_wide, SHIFT);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_reg       <= '0;
            res_valid_reg <= 1'b0;
            out_valid     <= 1'b0;
            dout          <= '0;
            dout_sat      <= 1'b0;
        end else if (ce) begin
            if (prod_valid)
                acc_reg <= prod_first ? prod : acc_reg + prod;
            res_valid_reg <= prod_valid & prod_last;
            out_valid     <= res_valid_reg;
            if (res_valid_reg) begin
                dout     <= OUT_W'(sat_clip(rnd, OUT_W));
                dout_sat <= sat_hit(rnd, OUT_W);
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe_dsp.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare.
// A second instance covers the no-accumulate, no-shift, single-stage, 24-bit-output variant.
module tb_cnn_mac_pipe_dsp;

    typedef struct {
        longint dout;
        bit     sat;
        int     lat;
        int     acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic ap_rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic               in_valid, in_ready, in_first, in_last, out_valid, out_ready, dout_sat;
    logic signed [9:0]  din0;
    logic signed [13:0] din1;
    logic signed [15:0] dout;

    logic               in_valid_b, in_ready_b, in_first_b, in_last_b, out_valid_b, out_ready_b, dout_sat_b;
    logic signed [9:0]  din0_b;
    logic signed [13:0] din1_b;
    logic signed [23:0] dout_b;

    exp_t q0[$];
    exp_t q1[$];
    bit   held0 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cnn_mac_pipe_dsp dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .dout_sat(dout_sat)
    );

    cnn_mac_pipe_dsp #(.ACCUM_EN(1'b0), .SHIFT(0), .MUL_STAGES(1), .OUT_W(24)) dut_b (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_first(in_first_b), .in_last(in_last_b),
        .din0(din0_b), .din1(din1_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .dout(dout_b), .dout_sat(dout_sat_b)
    );

    // Reference for the streaming test: round-half-up shift by 8 then clip to 16 bits.
    function automatic void model(input longint p, output longint d, output bit s);
        longint r;
        r = (p + 128) >>> 8;
        s = 1'b0;
        d = r;
        if (r > 32767) begin d = 32767; s = 1'b1; end
        if (r < -32768) begin d = -32768; s = 1'b1; end
    endfunction

    task automatic send(input int which, input int a, input int b, input bit f, input bit l,
                        input bit push, input longint ed, input bit es, input int lat);
        int   waits;
        exp_t e;
        @(negedge clk);
        if (which == 0) begin
            din0 = 10'(a); din1 = 14'(b); in_first = f; in_last = l; in_valid = 1'b1;
        end else begin
            din0_b = 10'(a); din1_b = 14'(b); in_first_b = f; in_last_b = l; in_valid_b = 1'b1;
        end
        waits = 0;
        #1;
        while ((which == 0) ? !in_ready : !in_ready_b) begin
            if (waits == 100) begin
                checks++; errors++;
                $display("FAIL send_timeout a=%0d b=%0d in_ready stayed 0, required 1", a, b);
                in_valid = 1'b0; in_valid_b = 1'b0;
                return;
            end
            @(negedge clk); #1;
            waits++;
        end
        if (push) begin
            e = '{ed, es, lat, cyc + 1};
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid_b = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (ap_rst_n) begin
            if (out_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result dout=%0d sat=%0d, required no result", dout, dout_sat);
                end else begin
                    e = q0[0];
                    if (!held0 && e.lat > 0) begin
                        checks++;
                        if (cyc - e.acc_edge + 1 != e.lat) begin
                            errors++;
                            $display("FAIL latency got=%0d required=%0d", cyc - e.acc_edge + 1, e.lat);
                        end
                    end
                    checks++;
                    if ($signed(dout) != e.dout || dout_sat !== e.sat) begin
                        errors++;
                        $display("FAIL result dout=%0d sat=%0d required dout=%0d sat=%0d", dout, dout_sat, e.dout, e.sat);
                    end else
                        $display("result dout=%0d sat=%0d ok", dout, dout_sat);
                    if (out_ready)
                        void'(q0.pop_front());
                    else begin
                        checks++;
                        if (in_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_in_ready got=%0b required=0", in_ready);
                        end
                    end
                end
            end
            held0 = out_valid && !out_ready;
        end else
            held0 = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (ap_rst_n && out_valid_b) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result_b dout=%0d, required no result", dout_b);
            end else begin
                e = q1.pop_front();
                if ($signed(dout_b) != e.dout || dout_sat_b !== e.sat || cyc - e.acc_edge + 1 != e.lat) begin
                    errors++;
                    $display("FAIL result_b dout=%0d sat=%0d lat=%0d required dout=%0d sat=%0d lat=%0d",
                             dout_b, dout_sat_b, cyc - e.acc_edge + 1, e.dout, e.sat, e.lat);
                end else
                    $display("result_b dout=%0d sat=%0d ok", dout_b, dout_sat_b);
            end
        end
    end

    initial begin
        longint ed;
        bit     es;
        ap_rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
        in_valid_b = 1'b0; in_first_b = 1'b0; in_last_b = 1'b0; din0_b = '0; din1_b = '0; out_ready_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== 16'sd0 || dout_sat !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ov=%0b dout=%0d sat=%0b rdy=%0b required 0/0/0/0", out_valid, dout, dout_sat, in_ready);
        end
        @(negedge clk);
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%0b required=1", in_ready);
        end

        // Single beat: -3*1000 = -3000 -> (-3000+128)>>>8 = -12
        send(0, -3, 1000, 1, 1, 1, -12, 0, 4);
        repeat (6) @(negedge clk);

        // Dot product 2*256+3*256-256 = 1024 -> 4
        send(0, 2, 256, 1, 0, 0, 0, 0, 0);
        send(0, 3, 256, 0, 0, 0, 0, 0, 0);
        send(0, -1, 256, 0, 1, 1, 4, 0, 4);
        repeat (6) @(negedge clk);

        // Saturation both ways, back-to-back dot products
        for (int i = 0; i < 4; i++) send(0, 511, 8191, i == 0, i == 3, i == 3, 32767, 1, 4);
        for (int i = 0; i < 4; i++) send(0, -512, 8191, i == 0, i == 3, i == 3, -32768, 1, 4);
        repeat (6) @(negedge clk);

        // Streaming with a 5-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    model(longint'(37 * i - 300) * longint'(1500 - 211 * i), ed, es);
                    send(0, 37 * i - 300, 1500 - 211 * i, 1, 1, 1, ed, es, 0);
                end
            end
            begin
                repeat (8) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);

        // Reset mid dot product discards the partial sum
        send(0, 100, 256, 1, 0, 0, 0, 0, 0);
        send(0, 100, 256, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got=%0b required=0", in_ready);
        end
        @(negedge clk);
        ap_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(0, 1, 256, 1, 0, 0, 0, 0, 0);
        send(0, 1, 256, 0, 1, 1, 2, 0, 4);
        repeat (6) @(negedge clk);

        // Variant instance: flags ignored, no shift, latency 3
        send(1, -512, -8192, 1, 1, 1, 4194304, 0, 3);
        send(1, 3, 5, 0, 0, 1, 15, 0, 3);
        send(1, -512, 8191, 0, 1, 1, -4193792, 0, 3);

        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
